// File: rtl/lc3_agu_pkg.sv
// Shared types and constants for the LC-3 address generation unit.
// Nothing here depends on the LC3_AGU_ACV_EN build option.
package lc3_agu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALC     = 3'd1,
        IND_REQ  = 3'd2,
        IND_WAIT = 3'd3,
        DONE     = 3'd4
    } agu_state_t;

    localparam logic [1:0] ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;

    localparam logic [15:0] SYS_LIMIT_DEF = 16'h3000;
    localparam logic [15:0] DEV_BASE_DEF  = 16'hFE00;

endpackage

// File: rtl/lc3_agu_sext.sv
// ADDR2 mux: picks the IR offset field and sign-extends it to WIDTH.
// Assumes WIDTH is at least 12.
module lc3_agu_sext
    import lc3_agu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [10:0]      field,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] offset
);

    // Offset selection and sign extension
    always_comb begin
        offset = {WIDTH{1'b0}};
        case (sel)
            ADDR2_ZERO:  offset = {WIDTH{1'b0}};
            ADDR2_OFF6:  offset = {{(WIDTH-6){field[5]}}, field[5:0]};
            ADDR2_OFF9:  offset = {{(WIDTH-9){field[8]}}, field[8:0]};
            ADDR2_OFF11: offset = {{(WIDTH-11){field[10]}}, field[10:0]};
            default:     offset = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/lc3_agu.sv
// LC-3 AGU: registered base + offset adder with optional memory-indirect hop.
// Define LC3_AGU_ACV_EN to compile in the user-mode access-control check.
module lc3_agu
    import lc3_agu_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] SYS_LIMIT = WIDTH'(SYS_LIMIT_DEF),
    parameter logic [WIDTH-1:0] DEV_BASE  = WIDTH'(DEV_BASE_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      ir,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] base,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic             indirect,
    input  logic             priv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_addr,
    output logic             out_acv,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    agu_state_t       state_r, state_n;
    logic [10:0]      field_r;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] base_r;
    logic             addr1_sel_r;
    logic [1:0]       addr2_sel_r;
    logic             indirect_r;
    logic             capture_s;

    logic             req_ready_r, req_ready_n;
    logic             out_valid_r, out_valid_n;
    logic [WIDTH-1:0] out_addr_r, out_addr_n;
    logic             out_acv_r, out_acv_n;
    logic             mem_req_r, mem_req_n;
    logic [WIDTH-1:0] mem_addr_r, mem_addr_n;

    logic [WIDTH-1:0] offset_s;
    logic [WIDTH-1:0] sum_s;
    logic             ptr_acv_s;
    logic             rd_acv_s;
    logic             unused_ir_s;

    assign unused_ir_s = ^ir[15:11];

    lc3_agu_sext #(.WIDTH(WIDTH)) u_sext (
        .field  (field_r),
        .sel    (addr2_sel_r),
        .offset (offset_s)
    );

    // Wraps modulo 2^WIDTH; the carry-out is intentionally dropped
    assign sum_s = (addr1_sel_r ? base_r : pc_r) + offset_s;

`ifdef LC3_AGU_ACV_EN
    logic priv_r;

    // Privilege captured with the rest of the request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            priv_r <= 1'b0;
        end else if (capture_s) begin
            priv_r <= priv;
        end else begin
            priv_r <= priv_r;
        end
    end

    // User mode may touch neither system space nor device space
    always_comb begin
        ptr_acv_s = priv_r && ((sum_s < SYS_LIMIT) || (sum_s >= DEV_BASE));
        rd_acv_s  = priv_r && ((mem_rdata < SYS_LIMIT) || (mem_rdata >= DEV_BASE));
    end
`else
    logic unused_cfg_s;

    assign unused_cfg_s = ^{priv, SYS_LIMIT, DEV_BASE};
    assign ptr_acv_s    = 1'b0;
    assign rd_acv_s     = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_n     = state_r;
        capture_s   = 1'b0;
        req_ready_n = req_ready_r;
        out_valid_n = out_valid_r;
        out_addr_n  = out_addr_r;
        out_acv_n   = out_acv_r;
        mem_req_n   = mem_req_r;
        mem_addr_n  = mem_addr_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    capture_s   = 1'b1;
                    req_ready_n = 1'b0;
                    state_n     = CALC;
                end else begin
                    req_ready_n = 1'b1;
                end
            end
            CALC: begin
                // A violating pointer is reported as-is and never dereferenced
                if (!indirect_r || ptr_acv_s) begin
                    out_addr_n = sum_s;
                    out_acv_n  = ptr_acv_s;
                    state_n    = DONE;
                end else begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = sum_s;
                    state_n    = IND_REQ;
                end
            end
            IND_REQ: begin
                if (mem_gnt) begin
                    mem_req_n = 1'b0;
                    state_n   = IND_WAIT;
                end else begin
                    mem_req_n = 1'b1;
                end
            end
            IND_WAIT: begin
                if (mem_rvalid) begin
                    out_addr_n = mem_rdata;
                    out_acv_n  = rd_acv_s;
                    state_n    = DONE;
                end else begin
                    state_n = IND_WAIT;
                end
            end
            DONE: begin
                // First DONE cycle raises out_valid; handshake happens after
                if (!out_valid_r) begin
                    out_valid_n = 1'b1;
                end else if (out_ready) begin
                    out_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    out_valid_n = 1'b1;
                end
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
                out_valid_n = 1'b0;
                mem_req_n   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
            out_addr_r  <= {WIDTH{1'b0}};
            out_acv_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_n;
            req_ready_r <= req_ready_n;
            out_valid_r <= out_valid_n;
            out_addr_r  <= out_addr_n;
            out_acv_r   <= out_acv_n;
            mem_req_r   <= mem_req_n;
            mem_addr_r  <= mem_addr_n;
        end
    end

    // Request capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_r     <= 11'd0;
            pc_r        <= {WIDTH{1'b0}};
            base_r      <= {WIDTH{1'b0}};
            addr1_sel_r <= 1'b0;
            addr2_sel_r <= 2'd0;
            indirect_r  <= 1'b0;
        end else if (capture_s) begin
            field_r     <= ir[10:0];
            pc_r        <= pc;
            base_r      <= base;
            addr1_sel_r <= addr1_sel;
            addr2_sel_r <= addr2_sel;
            indirect_r  <= indirect;
        end else begin
            field_r     <= field_r;
            pc_r        <= pc_r;
            base_r      <= base_r;
            addr1_sel_r <= addr1_sel_r;
            addr2_sel_r <= addr2_sel_r;
            indirect_r  <= indirect_r;
        end
    end

    assign req_ready = req_ready_r;
    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_acv   = out_acv_r;
    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_lc3_agu.sv
// Scoreboard bench for lc3_agu: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_lc3_agu;

    typedef struct {
        logic [15:0] addr;
        logic        acv;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } ptr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] base;
    logic        addr1_sel;
    logic [1:0]  addr2_sel;
    logic        indirect;
    logic        priv;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_addr;
    logic        out_acv;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    logic        r_gnt = 1'b0, r_rvalid = 1'b0;
    logic [15:0] r_rdata = 16'h0;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [15:0] m_rdata = 16'h0;
    logic        rdy_r = 1'b0, rdy_m = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          resp_en = 1'b0;
    int          gnt_force = -1;

    exp_t exp_q[$];
    ptr_t ptr_q[$];
    int   checks = 0;
    int   errors = 0;

    assign mem_gnt    = r_gnt | m_gnt;
    assign mem_rvalid = r_rvalid | m_rvalid;
    assign mem_rdata  = m_rvalid ? m_rdata : r_rdata;
    assign out_ready  = rdy_rand ? rdy_r : rdy_m;

    always #5 clk = ~clk;

    lc3_agu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ir         (ir),
        .pc         (pc),
        .base       (base),
        .addr1_sel  (addr1_sel),
        .addr2_sel  (addr2_sel),
        .indirect   (indirect),
        .priv       (priv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_acv    (out_acv),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic model_acv(input logic [15:0] a, input logic p);
`ifdef LC3_AGU_ACV_EN
        return p && (a < 16'h3000 || a >= 16'hFE00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] model_ea(input logic [15:0] ir_v, input logic [15:0] pc_v,
                                             input logic [15:0] base_v, input logic a1,
                                             input logic [1:0] a2);
        int n;
        int off;
        case (a2)
            2'd0:    n = 0;
            2'd1:    n = 6;
            2'd2:    n = 9;
            default: n = 11;
        endcase
        off = 0;
        if (n != 0) begin
            off = int'(ir_v) % (1 << n);
            if (off >= (1 << (n - 1))) off -= (1 << n);
        end
        return 16'((a1 ? int'(base_v) : int'(pc_v)) + off);
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 6))
            0:       return 16'h2FFF;
            1:       return 16'h3000;
            2:       return 16'hFDFF;
            3:       return 16'hFE00;
            4:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [15:0] ir_v, input logic [15:0] pc_v, input logic [15:0] base_v,
                         input logic a1, input logic [1:0] a2, input logic ind, input logic p,
                         input logic [15:0] rdata);
        int t = 0;
        logic [15:0] s;
        while (!req_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) check("req_ready_timeout", req_ready, 1);
        s = model_ea(ir_v, pc_v, base_v, a1, a2);
        if (ind && !model_acv(s, p)) begin
            ptr_q.push_back('{s, rdata});
            exp_q.push_back('{rdata, model_acv(rdata, p)});
        end else begin
            exp_q.push_back('{s, model_acv(s, p)});
        end
        ir = ir_v; pc = pc_v; base = base_v; addr1_sel = a1; addr2_sel = a2;
        indirect = ind; priv = p; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ir = 16'($urandom); pc = 16'($urandom); base = 16'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || !req_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Memory arbiter model: random grant delay and read latency
    initial begin
        forever begin
            @(posedge clk); #1;
            if (resp_en && mem_req) begin : serve
                ptr_t p;
                int d;
                int lat;
                if (ptr_q.size() == 0) begin
                    check("unexpected_mem_req", mem_req, 0);
                    p = '{mem_addr, 16'h0000};
                end else begin
                    p = ptr_q.pop_front();
                    check("mem_addr", mem_addr, p.addr);
                end
                d = (gnt_force >= 0) ? gnt_force : int'($urandom_range(0, 2));
                repeat (d) begin
                    @(posedge clk); #1;
                    check("mem_req_hold", mem_req, 1);
                    check("mem_addr_hold", mem_addr, p.addr);
                end
                r_gnt = 1'b1;
                @(posedge clk); #1;
                r_gnt = 1'b0;
                lat = $urandom_range(0, 2);
                repeat (lat) begin
                    @(posedge clk); #1;
                end
                r_rvalid = 1'b1;
                r_rdata  = p.data;
                @(posedge clk); #1;
                r_rvalid = 1'b0;
                r_rdata  = 16'($urandom);
            end
        end
    end

    // Random consumer back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) rdy_r = ($urandom_range(0, 3) != 0);
        end
    end

    // Result monitor: pops the scoreboard on each handshake, checks stall stability
    initial begin
        logic        hold_v;
        logic [15:0] hold_addr;
        logic        hold_acv;
        exp_t        e;
        hold_v = 1'b0;
        hold_addr = 16'h0;
        hold_acv = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_addr", out_addr, hold_addr);
                check("stall_acv", out_acv, hold_acv);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_addr", out_addr, e.addr);
                    check("out_acv", out_acv, e.acv);
                end
            end
            hold_v    = out_valid && !out_ready && rst_n;
            hold_addr = out_addr;
            hold_acv  = out_acv;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst_n = 1'b0; req_valid = 1'b0; ir = 16'h0; pc = 16'h0; base = 16'h0;
        addr1_sel = 1'b0; addr2_sel = 2'd0; indirect = 1'b0; priv = 1'b0;
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_acv", out_acv, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_en = 1'b1;

        // Direct latency and DONE stall
        rdy_m = 1'b0;
        issue(16'h01FF, 16'h3000, 16'h1234, 1'b0, 2'd2, 1'b0, 1'b0, 16'h0);
        check("lat_edge_n", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge_n1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge_n2", out_valid, 1);
        check("direct_addr", out_addr, 16'h2FFF);
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_req_ready", req_ready, 0);
        end
        rdy_m = 1'b1;
        @(posedge clk); #1;
        rdy_m = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_req_ready", req_ready, 1);
        rdy_m = 1'b1;

        // Wrap-around, indirect with held request, pointer in device space
        issue(16'h0001, 16'h0000, 16'hFFFF, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0);
        wait_drain();
        gnt_force = 2;
        issue(16'h0005, 16'h3000, 16'h0000, 1'b0, 2'd2, 1'b1, 1'b0, 16'h4000);
        wait_drain();
        gnt_force = -1;
        issue(16'h0000, 16'hFE00, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b1, 16'h1234);
        wait_drain();

        // Randomized traffic with back-pressure
        rdy_rand = 1'b1;
        repeat (150) begin
            issue(16'($urandom), pick16(), pick16(), 1'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), pick16());
        end
        wait_drain();
        rdy_rand = 1'b0;
        rdy_m = 1'b1;

        // Reset while waiting for pointer data
        resp_en = 1'b0;
        issue(16'h0005, 16'h1000, 16'h0000, 1'b0, 2'd2, 1'b1, 1'b0, 16'h7777);
        t = 0;
        while (!mem_req && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_test_mem_req", mem_req, 1);
        m_gnt = 1'b1;
        @(posedge clk); #1;
        m_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_addr", out_addr, 0);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_mem_addr", mem_addr, 0);
        exp_q.delete();
        ptr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_rvalid = 1'b1;
        m_rdata = 16'h5555;
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        repeat (3) begin
            check("late_rvalid_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        check("late_rvalid_req_ready", req_ready, 1);
        check("late_rvalid_out_addr", out_addr, 0);
        check("late_rvalid_out_acv", out_acv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_agu.md
# lc3_agu

Parametrised LC-3 address generation unit: computes `base + sign-extended IR offset` from a registered request, with an optional memory-indirect hop for LDI/STI and an optional privilege (ACV) check. It sits between the control FSM and the MAR load path and drives a single-outstanding read port to the memory arbiter. It supersedes the purely combinational address adder with a handshaked, multi-cycle unit.

## Interface
- `WIDTH`, 16: address/data width; offsets sign-extend to `WIDTH`.
- `SYS_LIMIT`, 16'h3000: first address outside system space.
- `DEV_BASE`, 16'hFE00: first address of device space.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, accepts request.
- `ir` in 16: instruction register.
- `pc` in WIDTH: incremented PC.
- `base` in WIDTH: SR1 (BaseR) value.
- `addr1_sel` in 1: 0 = `pc`, 1 = `base`.
- `addr2_sel` in 2: 0 = zero, 1 = `ir[5:0]`, 2 = `ir[8:0]`, 3 = `ir[10:0]`, all sign-extended.
- `indirect` in 1: use the sum as a pointer address.
- `priv` in 1: 1 = user mode.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `out_addr` out WIDTH: effective address.
- `out_acv` out 1: access-control violation flag.
- `mem_req` out 1: pointer read request.
- `mem_addr` out WIDTH: pointer address.
- `mem_gnt` in 1: request accepted by arbiter.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in WIDTH: read data.

## Operation
- States: IDLE, CALC, IND_REQ, IND_WAIT, DONE.
- IDLE: `req_ready`=1. On `req_valid` the unit registers `ir`, `pc`, `base`, the selects, `indirect` and `priv`, then goes to CALC.
- CALC: computes `sum` = ADDR1 + ADDR2 modulo 2^WIDTH, with wrap-around and no carry-out, and registers it.
  - `indirect`=0, or ACV on `sum`: go to DONE with `out_addr`=`sum`.
  - Otherwise: go to IND_REQ.
- IND_REQ: `mem_req`=1 and `mem_addr`=`sum`, both held stable until `mem_gnt`; then go to IND_WAIT.
- IND_WAIT: waits for `mem_rvalid`, captures `mem_rdata` as `out_addr`, evaluates ACV on it, then goes to DONE.
- `mem_rvalid` is ignored outside IND_WAIT.
- DONE: `out_valid`=1, with `out_addr` and `out_acv` stable, until `out_ready`; then return to IDLE.
  - No new request is accepted in the same cycle; `req_ready` rises the next cycle.
- ACV condition: `priv`=1 and (addr < `SYS_LIMIT` or addr ≥ `DEV_BASE`).
- `mem_gnt` and `mem_rvalid` in the same cycle while in IND_REQ is illegal; the arbiter never does this.

## Timing
- Reset values: `req_ready`=1, `out_valid`=0, `out_addr`=0, `out_acv`=0, `mem_req`=0, `mem_addr`=0. State is IDLE.
- Direct latency: accept at edge N, `out_valid` high after edge N+2 (CALC, then DONE).
- Indirect latency: 2 cycles + grant wait + read latency + 1.
- Reset asserted in any state returns the unit to IDLE immediately. A late `mem_rvalid` after reset is ignored.
- `out_valid` held with `out_ready` low: all outputs are frozen.

## Configuration
- `LC3_AGU_ACV_EN` defined: the ACV check is compiled in. A pointer ACV suppresses the memory read and reports `out_acv`=1 with `out_addr`=`sum`.
- Not defined: `out_acv` is tied to 0, `priv` is unused, and the indirect read is always issued.

## Structure
- Package `lc3_agu_pkg`:
  - state enum;
  - `addr2_sel` encodings;
  - default `SYS_LIMIT`/`DEV_BASE` constants.
- Sub-module `lc3_agu_sext`: combinational offset select and sign-extension to `WIDTH`.
- The FSM and registers live in the top module.

## Test plan
- `pc`=0x3000, `ir`[8:0]=0x1FF, `addr2_sel`=2, `addr1_sel`=0, direct → `out_addr`=0x2FFF, `out_valid` two edges after accept.
- `base`=0xFFFF, `ir`[5:0]=0x01, `addr2_sel`=1, `addr1_sel`=1 → `out_addr`=0x0000 (wrap).
- Indirect, `pc`=0x3000, `ir`[8:0]=0x005 → `mem_addr`=0x3005 held through a 2-cycle `mem_gnt` delay; `mem_rdata`=0x4000 → `out_addr`=0x4000.
- `out_ready` low for 3 cycles in DONE → `out_valid`/`out_addr` stable and `req_ready`=0; the pulse returns the unit to IDLE.
- With `LC3_AGU_ACV_EN`, `priv`=1, indirect sum 0xFE00 → no `mem_req`, `out_acv`=1. Without the macro → `mem_req` is issued and `out_acv`=0.
- `rst_n` low during IND_WAIT, then `mem_rvalid` pulses → all outputs at reset values and `out_valid` stays 0.
